// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEND  = 2'd1,
      ST_STALL = 2'd2,
      ST_ACK   = 2'd3
   } arb_state_e;

   localparam int STEAL_W = 16;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - pipeline, debug and memory signal bundle for the arbiter
interface dmem_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   import dmem_arbiter_pkg::*;

   logic [ADDR_W-1:0]  pipe_addr;
   logic [DATA_W-1:0]  pipe_wdata;
   logic               pipe_mem_read;
   logic               pipe_mem_write;
   logic [DATA_W-1:0]  pipe_rdata;
   logic               pipe_stall;

   logic               dbg_req;
   logic               dbg_we;
   logic [ADDR_W-1:0]  dbg_addr;
   logic [DATA_W-1:0]  dbg_wdata;
   logic               dbg_ack;
   logic [DATA_W-1:0]  dbg_rdata;

   logic [ADDR_W-1:0]  mem_addr;
   logic [DATA_W-1:0]  mem_wdata;
   logic               mem_write_en;
   logic               mem_read_en;
   logic [DATA_W-1:0]  mem_rdata;

   logic [STEAL_W-1:0] steal_count;

   modport master (
      output pipe_addr, pipe_wdata, pipe_mem_read, pipe_mem_write,
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output mem_rdata,
      input  pipe_rdata, pipe_stall, dbg_ack, dbg_rdata,
      input  mem_addr, mem_wdata, mem_write_en, mem_read_en, steal_count
   );

   modport slave (
      input  pipe_addr, pipe_wdata, pipe_mem_read, pipe_mem_write,
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  mem_rdata,
      output pipe_rdata, pipe_stall, dbg_ack, dbg_rdata,
      output mem_addr, mem_wdata, mem_write_en, mem_read_en, steal_count
   );

endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// rtl/dmem_arbiter_sat_counter.sv - incrementing counter that sticks at all-ones
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares data memory between MEM stage (priority) and a debug requester,
// stealing one frozen pipeline cycle when the debug side has waited MAX_WAIT busy cycles
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int MAX_WAIT = 8
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   localparam int                WAIT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   arb_state_e         r_state;
   arb_state_e         w_next;
   logic [WAIT_W-1:0]  r_wait_cnt;
   logic               r_cap_we;
   logic [ADDR_W-1:0]  r_cap_addr;
   logic [DATA_W-1:0]  r_cap_wdata;
   logic [DATA_W-1:0]  r_dbg_rdata;
   logic               w_pipe_busy;
   logic               w_wait_done;
   logic               w_dbg_owns;

   assign w_pipe_busy = bus.pipe_mem_read | bus.pipe_mem_write;
   assign w_wait_done = (r_wait_cnt == WAIT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (bus.dbg_req) w_next = ST_PEND;
         ST_PEND: begin
            if (!w_pipe_busy)     w_next = ST_ACK;
            else if (w_wait_done) w_next = ST_STALL;
         end
         ST_STALL: w_next = ST_ACK;
         ST_ACK:   if (!bus.dbg_req) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   // Debug owns memory only in a free PEND cycle or the stolen cycle; the pipeline owns it otherwise.
   always_comb begin
      w_dbg_owns       = (r_state == ST_STALL) || ((r_state == ST_PEND) && !w_pipe_busy);
      bus.pipe_stall   = (r_state == ST_STALL);
      bus.dbg_ack      = (r_state == ST_ACK);
      bus.mem_addr     = bus.pipe_addr;
      bus.mem_wdata    = bus.pipe_wdata;
      bus.mem_write_en = bus.pipe_mem_write;
      bus.mem_read_en  = bus.pipe_mem_read;
      if (w_dbg_owns) begin
         bus.mem_addr     = r_cap_addr;
         bus.mem_wdata    = r_cap_wdata;
         bus.mem_write_en = r_cap_we;
         bus.mem_read_en  = !r_cap_we;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wait_cnt  <= '0;
         r_cap_we    <= 1'b0;
         r_cap_addr  <= '0;
         r_cap_wdata <= '0;
         r_dbg_rdata <= '0;
      end else begin
         if ((r_state == ST_IDLE) && bus.dbg_req) begin
            r_cap_we    <= bus.dbg_we;
            r_cap_addr  <= bus.dbg_addr;
            r_cap_wdata <= bus.dbg_wdata;
            r_wait_cnt  <= '0;
         end else if ((r_state == ST_PEND) && w_pipe_busy && !w_wait_done) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
         end
         if (w_dbg_owns && !r_cap_we) begin
            r_dbg_rdata <= bus.mem_rdata;
         end
      end
   end

   sat_counter #(.W(STEAL_W)) u_steal_cnt (
      .clk     (clk),
      .rst_n   (reset),
      .i_inc   (r_state == ST_STALL),
      .o_count (bus.steal_count)
   );

   assign bus.pipe_rdata = bus.mem_rdata;
   assign bus.dbg_rdata  = r_dbg_rdata;

endmodule
